// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
// reg_idx_t / word_t are sized for the default configuration (32 x WORD_SIZE);
// RA_IDX / SP_IDX name the architectural return-address and stack-pointer GPRs.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
package rf_pkg;
  localparam int WORD_W = `WORD_SIZE;
  localparam int IDX_W  = 5;

  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam reg_idx_t RA_IDX = 5'd1;
  localparam reg_idx_t SP_IDX = 5'd2;
endpackage

// File: rtl/register_file_mp_if.sv
// Read / write / reserve bus of the multi-port register file.
// slave  : the register file (takes selects, write data and reserve requests)
// master : decode/issue + writeback side driving it
interface register_file_mp_if #(
  parameter int L2_NUM_REGS = 5,
  parameter int DATA_W      = 32,
  parameter int NUM_READ    = 2,
  parameter int NUM_WRITE   = 1
);
  logic [NUM_READ*L2_NUM_REGS-1:0]  i_rd_sel;
  logic [NUM_READ*DATA_W-1:0]       o_rd_data;
  logic [NUM_READ-1:0]              o_rd_busy;
  logic [NUM_WRITE-1:0]             i_wr_en;
  logic [NUM_WRITE*L2_NUM_REGS-1:0] i_wr_sel;
  logic [NUM_WRITE*DATA_W-1:0]      i_wr_data;
  logic                             i_rsv_en;
  logic [L2_NUM_REGS-1:0]           i_rsv_sel;
  logic                             o_rsv_ready;
  logic [L2_NUM_REGS:0]             o_busy_count;

  modport slave (
    input  i_rd_sel, i_wr_en, i_wr_sel, i_wr_data, i_rsv_en, i_rsv_sel,
    output o_rd_data, o_rd_busy, o_rsv_ready, o_busy_count
  );
  modport master (
    output i_rd_sel, i_wr_en, i_wr_sel, i_wr_data, i_rsv_en, i_rsv_sel,
    input  o_rd_data, o_rd_busy, o_rsv_ready, o_busy_count
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one bit per GPR, set by an accepted reservation, cleared by
// an enabled write (release). Reservation beats release on the same register.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_wr_en, i_wr_sel     write ports (releases)
//   i_rsv_en, i_rsv_sel   reserve request
//   o_rsv_ready           request would be accepted this cycle
//   o_busy                current busy vector (r0 always 0)
//   o_busy_count          registered popcount of o_busy
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int L2_NUM_REGS = 5,
  parameter int NUM_WRITE   = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_WRITE-1:0]             i_wr_en,
  input  logic [NUM_WRITE*L2_NUM_REGS-1:0] i_wr_sel,
  input  logic                             i_rsv_en,
  input  logic [L2_NUM_REGS-1:0]           i_rsv_sel,
  output logic                             o_rsv_ready,
  output logic [NUM_REGS-1:0]              o_busy,
  output logic [L2_NUM_REGS:0]             o_busy_count
);
  localparam int CW = L2_NUM_REGS + 1;

  logic [NUM_REGS-1:0] r_busy;
  logic [CW-1:0]       r_cnt;
  logic [NUM_REGS-1:0] w_rel, w_rsv, w_busy_nxt;
  logic [CW-1:0]       w_dec;
  logic                w_accept, w_inc;

  always_comb begin
    w_rel = '0;
    for (int p = 0; p < NUM_WRITE; p++)
      if (i_wr_en[p]) w_rel[i_wr_sel[p*L2_NUM_REGS +: L2_NUM_REGS]] = 1'b1;
    w_rel[0] = 1'b0;

    // A same-cycle release frees the slot, so a busy register can be re-reserved.
    o_rsv_ready = (i_rsv_sel == '0) || !r_busy[i_rsv_sel] || w_rel[i_rsv_sel];
    w_accept    = i_rsv_en && o_rsv_ready && (i_rsv_sel != '0);
    w_rsv       = '0;
    if (w_accept) w_rsv[i_rsv_sel] = 1'b1;

    // Re-reserving a register released this cycle is net zero: no +1, no -1.
    w_inc = w_accept && !r_busy[i_rsv_sel];
    w_dec = '0;
    for (int n = 0; n < NUM_REGS; n++)
      w_dec = w_dec + CW'(r_busy[n] & w_rel[n] & ~w_rsv[n]);

    w_busy_nxt = (r_busy & ~w_rel) | w_rsv;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= r_cnt + CW'(w_inc) - w_dec;
    end
  end

  assign o_busy       = r_busy;
  assign o_busy_count = r_cnt;
endmodule

// File: rtl/register_file_mp.sv
// Multi-port GPR file with optional write-to-read bypass, busy scoreboard and PC.
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   bus (slave)          read selects/data/busy, write ports, reserve handshake,
//                        busy count
//   i_load_pc(_data)     program counter load
//   o_program_counter    current PC
//   o_return_address     r1 stored value (no bypass)
//   o_stack_pointer      r2 stored value (no bypass)
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
module register_file_mp
  import rf_pkg::*;
#(
  parameter int              NUM_REGS    = 32,
  parameter int              L2_NUM_REGS = 5,
  parameter int              DATA_W      = `WORD_SIZE,
  parameter int              NUM_READ    = 2,
  parameter int              NUM_WRITE   = 1,
  parameter bit              BYPASS      = 1'b1,
  parameter logic [DATA_W-1:0] PC_RESET  = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  register_file_mp_if.slave bus,
  input  logic              i_load_pc,
  input  logic [DATA_W-1:0] i_load_pc_data,
  output logic [DATA_W-1:0] o_program_counter,
  output logic [DATA_W-1:0] o_return_address,
  output logic [DATA_W-1:0] o_stack_pointer
);
  localparam int L2 = L2_NUM_REGS;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_pc;
  logic [NUM_REGS-1:0] w_busy;

  // Ports are visited in ascending order, so the last NBA (highest port) wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int n = 0; n < NUM_REGS; n++) r_regs[n] <= '0;
      r_pc <= PC_RESET;
    end else begin
      if (i_load_pc) r_pc <= i_load_pc_data;
      for (int p = 0; p < NUM_WRITE; p++)
        if (bus.i_wr_en[p] && (bus.i_wr_sel[p*L2 +: L2] != '0))
          r_regs[bus.i_wr_sel[p*L2 +: L2]] <= bus.i_wr_data[p*DATA_W +: DATA_W];
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [L2-1:0]     w_sel;
    logic [DATA_W-1:0] w_data;
    logic              w_hit;

    assign w_sel = bus.i_rd_sel[k*L2 +: L2];

    always_comb begin
      w_data = r_regs[w_sel];
      w_hit  = 1'b0;
      if (BYPASS) begin
        for (int p = 0; p < NUM_WRITE; p++)
          if (bus.i_wr_en[p] && (bus.i_wr_sel[p*L2 +: L2] == w_sel)) begin
            w_hit  = 1'b1;
            w_data = bus.i_wr_data[p*DATA_W +: DATA_W];
          end
      end
      if (w_sel == '0) begin
        w_data = '0;
        w_hit  = 1'b0;
      end
    end

    assign bus.o_rd_data[k*DATA_W +: DATA_W] = w_data;
    // A bypassed read already carries the result, so it is not busy.
    assign bus.o_rd_busy[k] = w_busy[w_sel] & ~w_hit;
  end

  rf_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .L2_NUM_REGS(L2_NUM_REGS),
    .NUM_WRITE  (NUM_WRITE)
  ) u_sb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wr_en     (bus.i_wr_en),
    .i_wr_sel    (bus.i_wr_sel),
    .i_rsv_en    (bus.i_rsv_en),
    .i_rsv_sel   (bus.i_rsv_sel),
    .o_rsv_ready (bus.o_rsv_ready),
    .o_busy      (w_busy),
    .o_busy_count(bus.o_busy_count)
  );

  assign o_program_counter = r_pc;
  assign o_return_address  = r_regs[int'(RA_IDX)];
  assign o_stack_pointer   = r_regs[int'(SP_IDX)];
endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;
  localparam logic [31:0] PCR = 32'h0000_0004;

  logic        gclk = 1'b0;
  logic        grst_n = 1'b0;
  logic        load_pc;
  logic [31:0] load_pc_data, pc, ra, sp;
  int          n_chk = 0, n_fail = 0;

  always #5 gclk = ~gclk;

  register_file_mp_if #(.L2_NUM_REGS(5), .DATA_W(32), .NUM_READ(2), .NUM_WRITE(2)) bus ();

  register_file_mp #(
    .NUM_REGS(32), .L2_NUM_REGS(5), .DATA_W(32), .NUM_READ(2), .NUM_WRITE(2),
    .BYPASS(1'b1), .PC_RESET(PCR)
  ) dut (
    .i_clk(gclk), .i_rst_n(grst_n), .bus(bus.slave),
    .i_load_pc(load_pc), .i_load_pc_data(load_pc_data),
    .o_program_counter(pc), .o_return_address(ra), .o_stack_pointer(sp)
  );

  typedef struct {
    logic [1:0]  wr_en;
    logic [4:0]  ws0; logic [31:0] wd0;
    logic [4:0]  ws1; logic [31:0] wd1;
    logic        rsv_en; logic [4:0] rsv_sel;
    logic [4:0]  rs0, rs1;
    logic [31:0] e_rd0, e_rd1;
    logic        e_rdb0, e_rdy;
    logic [5:0]  e_cnt;
  } vec_t;
  vec_t v [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] ws0, input logic [31:0] wd0,
                       input logic [4:0] ws1, input logic [31:0] wd1,
                       input logic ren, input logic [4:0] rsel,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    bus.i_wr_en    = we;
    bus.i_wr_sel   = {ws1, ws0};
    bus.i_wr_data  = {wd1, wd0};
    bus.i_rsv_en   = ren;
    bus.i_rsv_sel  = rsel;
    bus.i_rd_sel   = {rs1, rs0};
  endtask

  initial begin
    //            we     ws0 wd0        ws1 wd1    ren rsel rs0 rs1 e_rd0      e_rd1   rdb0 rdy cnt
    v[0]  = '{2'b11, 5, 32'h11,    5, 32'h22, 0, 0,  5, 0, 32'h22,    32'h0,  0, 1, 0};
    v[1]  = '{2'b00, 0, 32'h0,     0, 32'h0,  0, 0,  5, 6, 32'h22,    32'h0,  0, 1, 0};
    v[2]  = '{2'b00, 0, 32'h0,     0, 32'h0,  1, 7,  7, 5, 32'h0,     32'h22, 0, 1, 1};
    v[3]  = '{2'b00, 0, 32'h0,     0, 32'h0,  1, 7,  7, 5, 32'h0,     32'h22, 1, 0, 1};
    v[4]  = '{2'b01, 7, 32'hAB,    0, 32'h0,  1, 7,  7, 5, 32'hAB,    32'h22, 0, 1, 1};
    v[5]  = '{2'b00, 0, 32'h0,     0, 32'h0,  0, 7,  7, 5, 32'hAB,    32'h22, 1, 0, 1};
    v[6]  = '{2'b01, 0, 32'hFFFF,  0, 32'h0,  1, 0,  0, 7, 32'h0,     32'hAB, 0, 1, 1};
    v[7]  = '{2'b00, 0, 32'h0,     0, 32'h0,  0, 0,  0, 7, 32'h0,     32'hAB, 0, 1, 1};
    v[8]  = '{2'b10, 0, 32'h0,     7, 32'h55, 0, 0,  7, 5, 32'h55,    32'h22, 0, 1, 0};
    v[9]  = '{2'b00, 0, 32'h0,     0, 32'h0,  1, 3,  3, 7, 32'h0,     32'h55, 0, 1, 1};
    v[10] = '{2'b11, 3, 32'h33,    9, 32'h99, 1, 4,  3, 9, 32'h33,    32'h99, 0, 1, 1};
    v[11] = '{2'b00, 0, 32'h0,     0, 32'h0,  0, 4,  3, 9, 32'h33,    32'h99, 0, 0, 1};

    // Reset with random inputs
    load_pc = 1'b0; load_pc_data = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge gclk);
      drive(2'($urandom), 5'($urandom), $urandom, 5'($urandom), $urandom,
            1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      load_pc = 1'($urandom); load_pc_data = $urandom;
    end
    @(posedge gclk); #1;
    chk("rst_cnt", 64'(bus.o_busy_count), 0);
    chk("rst_pc", 64'(pc), 64'(PCR));
    chk("rst_rdy", 64'(bus.o_rsv_ready), 1);
    @(negedge gclk);
    grst_n = 1'b1; load_pc = 1'b0; load_pc_data = '0;
    drive(0, 0, 0, 0, 0, 0, 5, 1, 2);
    #1;
    chk("rst_rd0", 64'(bus.o_rd_data[31:0]), 0);
    chk("rst_rd1", 64'(bus.o_rd_data[63:32]), 0);
    chk("rst_ra", 64'(ra), 0);
    chk("rst_sp", 64'(sp), 0);
    chk("rst_rdy5", 64'(bus.o_rsv_ready), 1);

    // Table-driven vectors: combinational checks before the edge, count after
    for (int i = 0; i < 12; i++) begin
      @(negedge gclk);
      drive(v[i].wr_en, v[i].ws0, v[i].wd0, v[i].ws1, v[i].wd1,
            v[i].rsv_en, v[i].rsv_sel, v[i].rs0, v[i].rs1);
      #1;
      chk($sformatf("v%0d_rd0", i), 64'(bus.o_rd_data[31:0]), 64'(v[i].e_rd0));
      chk($sformatf("v%0d_rd1", i), 64'(bus.o_rd_data[63:32]), 64'(v[i].e_rd1));
      chk($sformatf("v%0d_rdb0", i), 64'(bus.o_rd_busy[0]), 64'(v[i].e_rdb0));
      chk($sformatf("v%0d_rdy", i), 64'(bus.o_rsv_ready), 64'(v[i].e_rdy));
      @(posedge gclk); #1;
      chk($sformatf("v%0d_cnt", i), 64'(bus.o_busy_count), 64'(v[i].e_cnt));
    end

    // Mid-operation reset: r4 busy, reserve r3, write r1
    @(negedge gclk);
    drive(2'b01, 1, 32'h100, 0, 0, 1, 3, 3, 4);
    @(posedge gclk); #1;
    chk("mid_ra", 64'(ra), 64'h100);
    chk("mid_cnt", 64'(bus.o_busy_count), 2);
    drive(0, 0, 0, 0, 0, 0, 4, 3, 4);
    #1;
    chk("mid_rdb_pre", 64'(bus.o_rd_busy), 64'b11);
    grst_n = 1'b0;
    #1;
    chk("arst_ra", 64'(ra), 0);
    chk("arst_cnt", 64'(bus.o_busy_count), 0);
    chk("arst_rdb", 64'(bus.o_rd_busy), 0);
    chk("arst_rdy", 64'(bus.o_rsv_ready), 1);
    chk("arst_rd0", 64'(bus.o_rd_data[31:0]), 0);
    chk("arst_pc", 64'(pc), 64'(PCR));
    @(negedge gclk);
    grst_n = 1'b1;

    // PC load and sp write in the same cycle, then PC holds
    @(negedge gclk);
    drive(2'b01, 2, 32'h1000, 0, 0, 0, 0, 0, 0);
    load_pc = 1'b1; load_pc_data = 32'h80;
    #1;
    chk("pc_pre", 64'(pc), 64'(PCR));
    @(posedge gclk); #1;
    chk("pc_load", 64'(pc), 64'h80);
    chk("sp_load", 64'(sp), 64'h1000);
    @(negedge gclk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    load_pc = 1'b0; load_pc_data = 32'h1234;
    @(posedge gclk); #1;
    chk("pc_hold", 64'(pc), 64'h80);
    chk("sp_hold", 64'(sp), 64'h1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-write GPR file.
- Provides NUM_READ combinational read ports and NUM_WRITE synchronous write ports.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard with a reserve/release handshake, so an out-of-order or multi-cycle execution stage can track pending writebacks.
- Keeps the program counter and dedicated ra (r1) / sp (r2) outputs.
- Sits between decode/issue (reads, reserves) and writeback (writes, releases).

Parameters:
- NUM_REGS, 32, number of GPRs (power of two, >= 4).
- L2_NUM_REGS, 5, log2(NUM_REGS).
- DATA_W, `WORD_SIZE, register width in bits.
- NUM_READ, 2, number of read ports (1..4).
- NUM_WRITE, 1, number of write ports (1..3).
- BYPASS, 1, 1 = reads see same-cycle write data; 0 = reads see the registered value only.
- PC_RESET, 0, program counter value after reset.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rd_sel  in  NUM_READ*L2_NUM_REGS  packed read selects; port k uses bits [k*L2 +: L2].
- o_rd_data  out  NUM_READ*DATA_W  packed read data.
- o_rd_busy  out  NUM_READ  busy bit of each selected register (after bypass/release).
- i_wr_en  in  NUM_WRITE  per-port write enable.
- i_wr_sel  in  NUM_WRITE*L2_NUM_REGS  packed write selects.
- i_wr_data  in  NUM_WRITE*DATA_W  packed write data.
- i_rsv_en  in  1  reserve request: mark i_rsv_sel busy.
- i_rsv_sel  in  L2_NUM_REGS  register to reserve.
- o_rsv_ready  out  1  reservation accepted this cycle if i_rsv_en is high.
- o_busy_count  out  L2_NUM_REGS+1  number of currently busy registers.
- i_load_pc  in  1  load program counter.
- i_load_pc_data  in  DATA_W  new PC value.
- o_program_counter  out  DATA_W  current PC.
- o_return_address  out  DATA_W  r1 contents (registered value, no bypass).
- o_stack_pointer  out  DATA_W  r2 contents (registered value, no bypass).

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous, active-low on i_rst_n.
  - While reset is asserted: all GPRs = 0, PC = PC_RESET, all busy bits = 0, o_busy_count = 0.
  - Reset asserted mid-operation discards all pending reservations and writes.
- r0:
  - Reads as 0 on every port, including when bypassed.
  - Writes to r0 are ignored.
  - r0 never becomes busy; reserving r0 is always "ready" and has no effect.
- Writes:
  - Registered on the rising edge, 1-cycle latency to the stored value.
  - If multiple write ports target the same register, the highest-numbered port wins.
- Reads:
  - Combinational.
  - With BYPASS=1: if any enabled write port targets the read select (non-zero), o_rd_data is that write data (highest port wins).
  - With BYPASS=0: o_rd_data is the stored value.
- Scoreboard release:
  - An enabled write to register n (n != 0) clears busy[n] at the edge.
  - A write to a non-busy register is legal and leaves busy at 0.
- Scoreboard reserve:
  - o_rsv_ready = (i_rsv_sel == 0) or !busy[i_rsv_sel] or (a same-cycle enabled write targets i_rsv_sel).
  - When i_rsv_en && o_rsv_ready && i_rsv_sel != 0, busy[i_rsv_sel] is set at the edge.
  - A request with o_rsv_ready low is refused with no state change; the issuer holds and retries.
- Simultaneous release and reserve of the same register: the reservation wins, so busy ends at 1 and the write data is still stored.
- o_rd_busy[k]:
  - Equals busy[sel_k], masked to 0 when BYPASS=1 and a same-cycle write targets sel_k.
  - Always 0 for r0.
- o_busy_count:
  - Registered popcount of the busy vector.
  - Updated incrementally each edge: +1 for an accepted reservation of a non-busy register, -1 for each distinct busy register released and not re-reserved in the same cycle.
  - Never exceeds NUM_REGS-1.
- PC:
  - Loads i_load_pc_data at the edge when i_load_pc is high; otherwise holds.
  - The PC is independent of GPR writes.

Decomposition:
- Shared package rf_pkg: a reg_idx_t typedef, a word_t typedef, and the RA_IDX=1 / SP_IDX=2 constants.
- One sub-module, rf_scoreboard: owns the busy vector, the reserve/release logic and o_busy_count.
- The top level owns storage, write-port priority, bypass and the PC.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs, then release. All reads = 0, PC = PC_RESET, o_busy_count = 0, o_rsv_ready = 1.
- Dual-port priority: NUM_WRITE=2; port0 writes r5=0x11 and port1 writes r5=0x22 in the same cycle. The next cycle reads 0x22. With BYPASS=1, a same-cycle read of r5 returns 0x22.
- Reserve and retry: reserve r7, which is accepted and brings o_busy_count to 1. Reserve r7 again: o_rsv_ready=0 and the count stays 1. Write r7=0xAB: o_rsv_ready=1 that cycle, and the reserve is accepted with busy ending at 1. Read r7 = 0xAB.
- r0 handling: write r0=0xFFFF and reserve r0. Reads of r0 = 0, o_busy_count unchanged, o_rd_busy=0.
- Mid-operation reset: reserve r3 and r4, write r1=0x100, then pulse i_rst_n low between edges. Outputs clear immediately (asynchronously): o_return_address=0, busy cleared, o_busy_count=0.
- PC and sp: load PC=0x80 and write r2=0x1000 in the same cycle. The next cycle shows o_program_counter=0x80 and o_stack_pointer=0x1000; PC holds while i_load_pc=0.
